// File: rtl/deser400_pkg.sv
// ============================================================================
// Module   : deser400_pkg
// Purpose  : Shared types and helpers for the deser400 two-channel arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package deser400_pkg;

  localparam int DATA_W_DEFAULT = 16;

  typedef enum logic {
    CH_A = 1'b0,
    CH_B = 1'b1
  } chan_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  // Next value of a saturating drop counter; a same-cycle drop survives the clear.
  function automatic logic [15:0] drop_cnt_next(input logic [15:0] cur,
                                                input logic        clr,
                                                input logic        drop);
    logic [15:0] base;
    base = clr ? 16'h0000 : cur;
    if (drop && base != 16'hFFFF) begin
      return base + 16'h0001;
    end
    return base;
  endfunction

endpackage

`default_nettype wire

// File: rtl/deser400_arbiter_if.sv
// ============================================================================
// Module   : deser400_arbiter_if
// Purpose  : Capture, output handshake and status signals of deser400_arbiter.
//            Drop counters exist only with DESER400_ARB_STATS_EN defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface deser400_arbiter_if #(
  parameter int DATA_W = 16
);
  logic              run;
  logic              write_a;
  logic [DATA_W-1:0] data_a;
  logic              write_b;
  logic [DATA_W-1:0] data_b;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_chan;
  logic              ovf_a;
  logic              ovf_b;
  logic              busy;
`ifdef DESER400_ARB_STATS_EN
  logic [15:0]       drop_cnt_a;
  logic [15:0]       drop_cnt_b;
`endif

  modport master (
    output run, write_a, data_a, write_b, data_b, out_ready,
`ifdef DESER400_ARB_STATS_EN
    input  drop_cnt_a, drop_cnt_b,
`endif
    input  out_valid, out_data, out_chan, ovf_a, ovf_b, busy
  );

  modport slave (
    input  run, write_a, data_a, write_b, data_b, out_ready,
`ifdef DESER400_ARB_STATS_EN
    output drop_cnt_a, drop_cnt_b,
`endif
    output out_valid, out_data, out_chan, ovf_a, ovf_b, busy
  );

endinterface

`default_nettype wire

// File: rtl/deser400_arb_fifo.sv
// ============================================================================
// Module   : deser400_arb_fifo
// Purpose  : Per-channel sync FIFO, first-word-fall-through, drops on full.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module deser400_arb_fifo
  import deser400_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = 8
) (
  input  wire logic              clock,
  input  wire logic              res_n,
  input  wire logic              i_push,
  input  wire logic [DATA_W-1:0] i_din,
  input  wire logic              i_pop,
  output logic                   o_full,
  output logic                   o_empty,
  output logic                   o_drop,
  output logic [DATA_W-1:0]      o_dout
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_count;
  logic              w_wr;
  logic              w_rd;

  // Full is judged on the pre-pop count, so push+pop on a full buffer drops.
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_wr    = i_push && !o_full;
  assign o_drop  = i_push && o_full;
  assign w_rd    = i_pop && !o_empty;
  assign o_dout  = r_mem[r_rptr];

  always_ff @(posedge clock) begin
    if (w_wr) begin
      r_mem[r_wptr] <= i_din;
    end
  end

  always_ff @(posedge clock or negedge res_n) begin
    if (!res_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_rd) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_wr && !w_rd) begin
        r_count <= r_count + 1'b1;
      end else if (!w_wr && w_rd) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/deser400_arbiter.sv
// ============================================================================
// Module   : deser400_arbiter
// Purpose  : Merges deser400 channels A/B into one tagged round-robin stream.
//            Optional macro DESER400_ARB_STATS_EN adds per-channel drop counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module deser400_arbiter
  import deser400_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int FIFO_DEPTH = 8
) (
  input  wire logic         clock,
  input  wire logic         res_n,
  deser400_arbiter_if.slave bus
);

  logic              w_full_a, w_full_b;
  logic              w_empty_a, w_empty_b;
  logic              w_drop_a, w_drop_b;
  logic [DATA_W-1:0] w_dout_a, w_dout_b;
  logic              w_load, w_take, w_pop_a, w_pop_b, w_clr, w_busy;
  chan_e             w_grant;

  state_e            r_state;
  chan_e             r_last;
  chan_e             r_out_chan;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_run_q;
  logic              r_ovf_a, r_ovf_b;

  deser400_arb_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clock(clock), .res_n(res_n),
    .i_push(bus.write_a && bus.run), .i_din(bus.data_a), .i_pop(w_pop_a),
    .o_full(w_full_a), .o_empty(w_empty_a), .o_drop(w_drop_a), .o_dout(w_dout_a)
  );

  deser400_arb_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clock(clock), .res_n(res_n),
    .i_push(bus.write_b && bus.run), .i_din(bus.data_b), .i_pop(w_pop_b),
    .o_full(w_full_b), .o_empty(w_empty_b), .o_drop(w_drop_b), .o_dout(w_dout_b)
  );

  // Output register refills in the same cycle it is consumed: no bubble.
  assign w_load = !r_out_valid || bus.out_ready;
  assign w_take = w_load && (!w_empty_a || !w_empty_b);
  assign w_clr  = bus.run && !r_run_q;
  assign w_busy = !w_empty_a || !w_empty_b || r_out_valid;

  always_comb begin
    w_grant = CH_A;
    if (!w_empty_a && !w_empty_b) begin
      w_grant = (r_last == CH_B) ? CH_A : CH_B;
    end else if (w_empty_a) begin
      w_grant = CH_B;
    end
  end

  assign w_pop_a = w_take && (w_grant == CH_A);
  assign w_pop_b = w_take && (w_grant == CH_B);

  always_ff @(posedge clock or negedge res_n) begin
    if (!res_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= CH_A;
      r_last      <= CH_B;
      r_run_q     <= 1'b0;
      r_ovf_a     <= 1'b0;
      r_ovf_b     <= 1'b0;
    end else begin
      r_run_q <= bus.run;
      r_ovf_a <= (w_clr ? 1'b0 : r_ovf_a) | w_drop_a;
      r_ovf_b <= (w_clr ? 1'b0 : r_ovf_b) | w_drop_b;
      if (w_load) begin
        r_out_valid <= w_take;
      end
      if (w_take) begin
        r_out_data <= (w_grant == CH_A) ? w_dout_a : w_dout_b;
        r_out_chan <= w_grant;
        r_last     <= w_grant;
      end
    end
  end

  always_ff @(posedge clock or negedge res_n) begin
    if (!res_n) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (bus.run) r_state <= ACTIVE;
        ACTIVE:  if (!bus.run) r_state <= DRAIN;
        DRAIN:   if (bus.run) r_state <= ACTIVE;
                 else if (!w_busy) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef DESER400_ARB_STATS_EN
  logic [15:0] r_drop_cnt_a, r_drop_cnt_b;

  always_ff @(posedge clock or negedge res_n) begin
    if (!res_n) begin
      r_drop_cnt_a <= '0;
      r_drop_cnt_b <= '0;
    end else begin
      r_drop_cnt_a <= drop_cnt_next(r_drop_cnt_a, w_clr, w_drop_a);
      r_drop_cnt_b <= drop_cnt_next(r_drop_cnt_b, w_clr, w_drop_b);
    end
  end

  assign bus.drop_cnt_a = r_drop_cnt_a;
  assign bus.drop_cnt_b = r_drop_cnt_b;
`endif

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_chan  = r_out_chan;
  assign bus.ovf_a     = r_ovf_a;
  assign bus.ovf_b     = r_ovf_b;
  assign bus.busy      = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_deser400_arbiter.sv
// ============================================================================
// Module   : tb_deser400_arbiter
// Purpose  : Self-checking bench for deser400_arbiter against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_deser400_arbiter;
  import deser400_pkg::*;

  localparam int DW    = 16;
  localparam int DEPTH = 8;

  logic clock = 1'b0;
  logic res_n = 1'b0;
  always #5 clock = ~clock;

  deser400_arbiter_if #(.DATA_W(DW)) bus ();

  deser400_arbiter #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock),
    .res_n(res_n),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: per-channel queues, held output word and sticky flags.
  logic [DW-1:0] qa[$], qb[$];
  bit            mv, mc, mlast, movf_a, movf_b, mrun_q;
  logic [DW-1:0] md;
  int            mdrop_a, mdrop_b;
  logic [DW-1:0] acc_a[$], acc_b[$];
  bit            acc_ch[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    qa.delete(); qb.delete();
    mv = 0; mc = 0; md = '0; mlast = 1; movf_a = 0; movf_b = 0; mrun_q = 0;
    mdrop_a = 0; mdrop_b = 0;
  endtask

  task automatic model_edge();
    int sa, sb;
    sa = qa.size();
    sb = qb.size();
    if (bus.run && !mrun_q) begin
      movf_a = 0; movf_b = 0; mdrop_a = 0; mdrop_b = 0;
    end
    if (!mv || bus.out_ready) begin
      if (sa > 0 && (sb == 0 || mlast == 1)) begin
        md = qa.pop_front(); mc = 0; mv = 1; mlast = 0;
      end else if (sb > 0) begin
        md = qb.pop_front(); mc = 1; mv = 1; mlast = 1;
      end else begin
        mv = 0;
      end
    end
    if (bus.run && bus.write_a) begin
      if (sa >= DEPTH) begin movf_a = 1; if (mdrop_a < 65535) mdrop_a++; end
      else qa.push_back(bus.data_a);
    end
    if (bus.run && bus.write_b) begin
      if (sb >= DEPTH) begin movf_b = 1; if (mdrop_b < 65535) mdrop_b++; end
      else qb.push_back(bus.data_b);
    end
    mrun_q = bus.run;
  endtask

  task automatic check_all();
    check("out_valid", bus.out_valid, mv);
    check("out_data", bus.out_data, md);
    check("out_chan", bus.out_chan, mc);
    check("ovf_a", bus.ovf_a, movf_a);
    check("ovf_b", bus.ovf_b, movf_b);
    check("busy", bus.busy, (qa.size() != 0 || qb.size() != 0 || mv));
`ifdef DESER400_ARB_STATS_EN
    check("drop_cnt_a", bus.drop_cnt_a, mdrop_a);
    check("drop_cnt_b", bus.drop_cnt_b, mdrop_b);
`endif
  endtask

  task automatic step();
    if (bus.out_valid && bus.out_ready) begin
      acc_ch.push_back(bus.out_chan);
      if (bus.out_chan) acc_b.push_back(bus.out_data);
      else acc_a.push_back(bus.out_data);
    end
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic clear_acc();
    acc_a.delete(); acc_b.delete(); acc_ch.delete();
  endtask

  task automatic do_reset();
    res_n = 1'b0;
    #1;
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_chan", bus.out_chan, 0);
    check("rst_ovf", {bus.ovf_a, bus.ovf_b}, 0);
    check("rst_busy", bus.busy, 0);
    model_reset();
    bus.write_a = 0; bus.write_b = 0;
    @(negedge clock);
    res_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.run = 0; bus.write_a = 0; bus.write_b = 0;
    bus.data_a = '0; bus.data_b = '0; bus.out_ready = 0;
    #3;
    do_reset();

    // Latency: one word through empty path
    bus.run = 1; bus.out_ready = 1;
    step(); step();
    bus.write_a = 1; bus.data_a = 16'h1234;
    step();
    bus.write_a = 0;
    check("lat_n1_valid", bus.out_valid, 0);
    step();
    check("lat_n2_valid", bus.out_valid, 1);
    check("lat_n2_data", bus.out_data, 16'h1234);
    check("lat_n2_chan", bus.out_chan, 0);
    step();
    check("lat_n3_valid", bus.out_valid, 0);

    // Fairness after reset: A wins the first tie, then strict alternation
    do_reset();
    bus.run = 1; bus.out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      bus.write_a = 1; bus.data_a = 16'hA000 + 16'(i);
      bus.write_b = 1; bus.data_b = 16'hB000 + 16'(i);
      step();
    end
    bus.write_a = 0; bus.write_b = 0;
    step();
    clear_acc();
    bus.out_ready = 1;
    for (int i = 0; i < 8; i++) step();
    check("fair_count", acc_ch.size(), 8);
    for (int i = 0; i < acc_ch.size(); i++) check("fair_chan", acc_ch[i], i % 2);

    // Overflow: hold a B word in the output, then 10 A strobes into depth 8
    bus.out_ready = 0;
    bus.write_b = 1; bus.data_b = 16'hBEEF;
    step();
    bus.write_b = 0;
    step();
    for (int i = 0; i < 10; i++) begin
      bus.write_a = 1; bus.data_a = 16'hC000 + 16'(i);
      step();
    end
    bus.write_a = 0;
    check("ovf_a_set", bus.ovf_a, 1);
`ifdef DESER400_ARB_STATS_EN
    check("drop_cnt_a_2", bus.drop_cnt_a, 2);
`endif
    clear_acc();
    bus.out_ready = 1;
    for (int i = 0; i < 12; i++) step();
    check("ovf_a_words", acc_a.size(), 8);
    check("ovf_b_words", acc_b.size(), 1);
    for (int i = 0; i < acc_a.size(); i++) check("ovf_order", acc_a[i], 16'hC000 + 16'(i));

    // Drain: 5 words buffered, run drops, strobes ignored, busy falls
    bus.out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      bus.write_a = 1; bus.data_a = 16'hD000 + 16'(i);
      step();
    end
    bus.write_a = 0;
    bus.run = 0;
    clear_acc();
    bus.out_ready = 1;
    begin
      int budget;
      budget = 40;
      while (budget > 0) begin
        bus.write_a = 1'($urandom); bus.data_a = 16'($urandom);
        bus.write_b = 1'($urandom); bus.data_b = 16'($urandom);
        step();
        budget--;
        if (!bus.busy) break;
      end
      check("drain_timeout", (budget == 0 && bus.busy), 0);
    end
    bus.write_a = 0; bus.write_b = 0;
    check("drain_words", acc_a.size(), 5);
    check("drain_b_none", acc_b.size(), 0);
    check("drain_ovf_kept", bus.ovf_a, 1);
    bus.run = 1;
    step();
    check("run_rise_ovf_clr", bus.ovf_a, 0);

    // Backpressure: random streams and random out_ready
    for (int i = 0; i < 300; i++) begin
      bus.write_a = 1'($urandom); bus.data_a = 16'($urandom);
      bus.write_b = 1'($urandom); bus.data_b = 16'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    bus.write_a = 0; bus.write_b = 0; bus.out_ready = 1;
    for (int i = 0; i < 2 * DEPTH + 4; i++) step();
    check("bp_idle", bus.busy, 0);

    // Reset mid-burst, then first tie goes to A
    bus.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      bus.write_a = 1; bus.data_a = 16'h5A00 + 16'(i);
      bus.write_b = 1; bus.data_b = 16'h5B00 + 16'(i);
      step();
    end
    do_reset();
    bus.run = 1;
    bus.write_a = 1; bus.data_a = 16'h0A0A;
    bus.write_b = 1; bus.data_b = 16'h0B0B;
    step();
    bus.write_a = 0; bus.write_b = 0;
    step();
    check("post_rst_tie_chan", bus.out_chan, 0);
    check("post_rst_tie_data", bus.out_data, 16'h0A0A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
